// File: rtl/instr_mem_reader_if.sv
// Bundle between the instruction-memory reader and its neighbours: the packed
// memory and start request come in, and the one-instruction-per-handshake
// stream to the fetch stage goes out.
interface instr_mem_reader_if #(
    parameter int unsigned INSTR_W = 8,
    parameter int unsigned DEPTH   = 8
);
    localparam int unsigned PC_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [INSTR_W*DEPTH-1:0] instrMemBits;
    logic                     start;
    logic                     out_ready;
    logic                     out_valid;
    logic [INSTR_W-1:0]       out_instr;
    logic [PC_W-1:0]          out_pc;
    logic                     busy;
    logic                     done;

    // Driver side: the input-mode block and the fetch stage.
    modport master (
        output instrMemBits, start, out_ready,
        input  out_valid, out_instr, out_pc, busy, done
    );

    // The reader itself.
    modport slave (
        input  instrMemBits, start, out_ready,
        output out_valid, out_instr, out_pc, busy, done
    );
endinterface

// File: rtl/instr_mem_reader.sv
// Instruction memory reader: on start, snapshots the packed instruction memory
// and streams it slot 0 first, one instruction per valid/ready handshake, to the
// IF stage. All outputs come straight from flops.
// Optional feature: define INSTR_HALT_DETECT_EN to stop the stream at the first
// slot equal to HALT_CODE (that slot is never presented).
module instr_mem_reader #(
    parameter int unsigned        INSTR_W   = 8,
    parameter int unsigned        DEPTH     = 8,
    parameter logic [INSTR_W-1:0] HALT_CODE = 8'hFF
) (
    input logic              clk,
    input logic              rst_n,
    instr_mem_reader_if.slave bus
);
    localparam int unsigned PC_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef INSTR_HALT_DETECT_EN
    localparam bit HaltEn = 1'b1;
`else
    localparam bit HaltEn = 1'b0;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StSend,
        StDone
    } state_e;

    state_e                   state_q, state_d;
    logic [INSTR_W*DEPTH-1:0] snapshot_q, snapshot_d;
    logic [PC_W-1:0]          pc_q, pc_d;
    logic                     out_valid_q, out_valid_d;
    logic [INSTR_W-1:0]       out_instr_q, out_instr_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic [INSTR_W-1:0]       slots [DEPTH];
    logic [PC_W-1:0]          nxt_pc;
    logic [PC_W-1:0]          nxt_idx;
    logic [INSTR_W-1:0]       nxt_slot;
    logic                     halt_next;
    logic                     last_slot;
    logic                     xfer;

    // Unpack the snapshot and pick the slot that would be presented next.
    always_comb begin
        for (int k = 0; k < int'(DEPTH); k++) begin
            slots[k] = snapshot_q[k*INSTR_W +: INSTR_W];
        end
        nxt_pc    = pc_q + PC_W'(1);
        // LOAD presents slot 0; SEND presents the slot after the current one.
        nxt_idx   = (state_q == StLoad) ? '0 : nxt_pc;
        nxt_slot  = slots[nxt_idx];
        halt_next = HaltEn && (nxt_slot == HALT_CODE);
        last_slot = (pc_q == PC_W'(DEPTH - 1));
        xfer      = out_valid_q && bus.out_ready;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        snapshot_d  = snapshot_q;
        pc_d        = pc_q;
        out_instr_d = out_instr_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    snapshot_d = bus.instrMemBits;
                    pc_d       = '0;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                if (halt_next) begin
                    state_d = StDone;
                end else begin
                    out_instr_d = nxt_slot;
                    state_d     = StSend;
                end
            end
            StSend: begin
                if (xfer) begin
                    // pc never wraps: the last slot (or a halt) ends the stream.
                    if (last_slot || halt_next) begin
                        state_d = StDone;
                    end else begin
                        pc_d        = nxt_pc;
                        out_instr_d = nxt_slot;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered copies of the decoded next state.
        out_valid_d = (state_d == StSend);
        busy_d      = (state_d == StLoad) || (state_d == StSend);
        done_d      = (state_d == StDone);
    end

    // State and output registers; reset aborts any stream immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            snapshot_q  <= '0;
            pc_q        <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            snapshot_q  <= snapshot_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_pc    = pc_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_instr_mem_reader.sv
// Self-checking bench for instr_mem_reader: directed scenarios plus randomized
// memories and ready patterns, checked against a slot-list model of the stream.
module tb_instr_mem_reader;
    localparam int unsigned INSTR_W = 8;
    localparam int unsigned DEPTH   = 8;
    localparam logic [63:0] MemA    = 64'h89A8908C8A898888;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    instr_mem_reader_if #(.INSTR_W(INSTR_W), .DEPTH(DEPTH)) bus ();

    instr_mem_reader #(
        .INSTR_W  (INSTR_W),
        .DEPTH    (DEPTH),
        .HALT_CODE(8'hFF)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected stream: slots in order, truncated at the first halt code if enabled.
    function automatic void build(input logic [63:0] mem);
        logic [7:0] slot;
        exp_q.delete();
        for (int k = 0; k < int'(DEPTH); k++) begin
            slot = mem[k*8 +: 8];
`ifdef INSTR_HALT_DETECT_EN
            if (slot == 8'hFF) break;
`endif
            exp_q.push_back(slot);
        end
    endfunction

    // mode: 0 ready always, 1 ready 1,0,0 repeating, 2 random ready.
    task automatic stream(input logic [63:0] mem, input int mode, input bit hold,
                          input int disturb_at, input int reset_at);
        int idx;
        int cyc;
        int n;
        bit fin;
        bit disturbed;
        idx = 0;
        cyc = 0;
        fin = 1'b0;
        disturbed = 1'b0;
        build(mem);
        n = exp_q.size();
        bus.instrMemBits = mem;
        bus.start = 1'b1;
        step();
        if (!hold) bus.start = 1'b0;
        chk("load_valid", bus.out_valid, 0);
        chk("load_busy", bus.busy, 1);
        chk("load_done", bus.done, 0);
        bus.out_ready = 1'($urandom_range(0, 1));
        step();
        chk("first_valid", bus.out_valid, (n > 0) ? 1 : 0);
        while (!fin && cyc < 100) begin
            if (bus.done === 1'b1) begin
                chk("done_count", idx, n);
                chk("done_valid", bus.out_valid, 0);
                chk("done_busy", bus.busy, 0);
                fin = 1'b1;
            end else begin
                chk("send_busy", bus.busy, 1);
                if (idx < n) begin
                    chk("send_valid", bus.out_valid, 1);
                    chk("instr", bus.out_instr, exp_q[idx]);
                    chk("pc", bus.out_pc, idx);
                end else begin
                    chk("done_missing", bus.done, 1);
                end
                if (reset_at >= 0 && idx == reset_at) begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_valid", bus.out_valid, 0);
                    chk("rst_busy", bus.busy, 0);
                    chk("rst_done", bus.done, 0);
                    chk("rst_pc", bus.out_pc, 0);
                    chk("rst_instr", bus.out_instr, 0);
                    bus.start = 1'b0;
                    step();
                    rst_n = 1'b1;
                    for (int i = 0; i < 3; i++) begin
                        step();
                        chk("post_rst_valid", bus.out_valid, 0);
                        chk("post_rst_busy", bus.busy, 0);
                    end
                    return;
                end
                if (disturb_at >= 0 && idx == disturb_at && !disturbed) begin
                    bus.instrMemBits = {$urandom, $urandom};
                    bus.start = 1'b1;
                    disturbed = 1'b1;
                end else if (!hold) begin
                    bus.start = 1'b0;
                end
                case (mode)
                    0: bus.out_ready = 1'b1;
                    1: bus.out_ready = (cyc % 3 == 0);
                    default: bus.out_ready = 1'($urandom_range(0, 1));
                endcase
                if (bus.out_valid && bus.out_ready) idx++;
                step();
                cyc++;
            end
        end
        chk("stream_timeout", fin, 1);
        step();
        chk("idle_done", bus.done, 0);
        chk("idle_valid", bus.out_valid, 0);
        chk("idle_busy", bus.busy, 0);
    endtask

    initial begin
        logic [63:0] mem;
        bus.instrMemBits = '0;
        bus.start = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state, then idle with start low.
        step();
        chk("reset_valid", bus.out_valid, 0);
        chk("reset_instr", bus.out_instr, 0);
        chk("reset_pc", bus.out_pc, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_valid", bus.out_valid, 0);
            chk("idle_busy", bus.busy, 0);
            chk("idle_done", bus.done, 0);
        end

        // Continuous ready, toggled ready, random ready with mid-stream disturbance.
        stream(MemA, 0, 1'b0, -1, -1);
        stream(MemA, 1, 1'b0, -1, -1);
        stream(MemA, 2, 1'b0, 3, -1);
        // Reset at transfer 5, then a normal stream afterwards.
        stream(MemA, 0, 1'b0, -1, 5);
        stream(MemA, 0, 1'b0, -1, -1);

        // Halt code in slot 3 and in slot 0.
        stream(64'h89A8908CFF898888, 0, 1'b0, -1, -1);
        stream(64'h89A8908C8A8988FF, 2, 1'b0, -1, -1);

        // Start held high: back-to-back streams, each with a fresh snapshot.
        for (int s = 0; s < 3; s++) begin
            mem = {$urandom, $urandom};
            stream(mem, 0, 1'b1, -1, -1);
        end
        bus.start = 1'b0;
        step();
        chk("held_release_busy", bus.busy, 0);

        // Random memories (sometimes containing a halt code) and random ready.
        for (int r = 0; r < 12; r++) begin
            mem = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) mem[$urandom_range(0, 7)*8 +: 8] = 8'hFF;
            stream(mem, 2, 1'b0, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
